disparity_select: RTL and testbench
===================================

Name: disparity_select

Overview:
- Winner-take-all stage directly downstream of the per-block SSD calculator in the stereo pipeline.
- For each left-image centre pixel, consumes the stream of SSD scores, one per candidate right-image offset, and selects the offset with minimum SSD as the disparity.
- Writes one 8-bit disparity per pixel into the disparity result BRAM and emits a per-pixel valid strobe plus an end-of-frame pulse to the stereo top-level FSM.

Parameters:
- SSD_WIDTH, 22, SSD score width (36 px × 255² = 2,340,900 < 2^22).
- DISP_WIDTH, 8, disparity/candidate counter width.
- IMG_W, 240, pixel-x extent (x in 0..IMG_W-1).
- IMG_H, 320, pixel-y extent (y in 0..IMG_H-1).
- X_LAST, 235, last valid centre x of a frame.
- Y_LAST, 315, last valid centre y of a frame.
- SSD_THRESH, 2^22-1, max acceptable best SSD; a larger best score gives INVALID_DISP.
- INVALID_DISP, 8'hFF, code written when there is no acceptable match.

Ports:
- clk_100mhz  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- ssd_valid_in  in  1  ssd_in and flags valid this cycle.
- ssd_in  in  SSD_WIDTH  SSD score of current candidate.
- ssd_first_in  in  1  first candidate for a new left pixel.
- ssd_last_in  in  1  last candidate for the current left pixel (may coincide with first).
- left_x_in  in  $clog2(IMG_W)  centre x, sampled on first beat.
- left_y_in  in  $clog2(IMG_H)  centre y, sampled on first beat.
- result_we  out  1  BRAM write enable (1-cycle pulse).
- result_addr  out  $clog2(IMG_W*IMG_H)  = IMG_W*y + x.
- result_din  out  DISP_WIDTH  disparity written.
- disp_valid_out  out  1  same cycle as result_we.
- disp_out  out  DISP_WIDTH  same value as result_din.
- frame_done_out  out  1  pulse with the write of (X_LAST, Y_LAST).
- seq_error_out  out  1  sticky protocol-error flag.

Behaviour:
- Reset (sync, active-high): all outputs 0, state IDLE, best_ssd all-ones, best_disp 0, cand_cnt 0, seq_error_out cleared. Reset mid-pixel discards partial results; no write is issued.
- States:
  - IDLE: waits for ssd_valid_in & ssd_first_in.
  - ACCUM: accumulating candidates.
  - After a last beat, a 1-cycle output register stage follows; state returns to IDLE, or stays in ACCUM if a new first arrives the same cycle.
- First beat:
  - Sets best_ssd=ssd_in, best_disp=0, cand_cnt=1.
  - Latches x/y.
- Each further valid beat: if ssd_in < best_ssd (strict), best_ssd<=ssd_in and best_disp<=cand_cnt. Ties keep the smaller disparity. cand_cnt then increments, saturating at 2^DISP_WIDTH-1; the saturated index is never promoted to best.
- Last beat:
  - Comparison includes this beat.
  - Next cycle: result_we=disp_valid_out=1.
  - result_din=disp_out=best_disp, or INVALID_DISP if final best_ssd > SSD_THRESH.
  - result_addr from latched x/y.
  - Latency: last beat → write = 1 cycle.
- First & last on the same beat: single-candidate pixel, disparity 0 (threshold still applies).
- ssd_valid_in low: no state change; gaps of any length are legal.
- frame_done_out pulses together with result_we when latched x==X_LAST and y==Y_LAST.
- Protocol errors (set seq_error_out, held until reset):
  - first in ACCUM without a preceding last: partial pixel discarded, restart with the new beat.
  - Valid non-first beat in IDLE: beat ignored.
- Back-to-back pixels: a last at cycle n and a first at n+1 are fully supported; throughput is one candidate per cycle.
- Address arithmetic: IMG_W*y computed as constant multiply; result width is $clog2(IMG_W*IMG_H), no overflow for in-range x/y.

Decomposition:
- Shared package stereo_pkg holds:
  - SSD_WIDTH, DISP_WIDTH, IMG_W, IMG_H, INVALID_DISP constants.
  - ds_state_t enum {DS_IDLE, DS_ACCUM}.
- One natural sub-module: min_tracker (compare/update best_ssd, best_disp, cand_cnt with saturation).
- Address/output register logic lives in disparity_select.

Test Plan:
- Ramp min: x=10,y=20, SSD {500,300,100,400} first..last → one cycle after last: result_we=1, addr=4810, din=2, frame_done_out=0.
- Tie: SSD {50,50,70} → din=0 (earliest minimum wins).
- Threshold: SSD_THRESH=1000, SSD {2000,1500} → din=8'hFF; repeat with {2000,900} → din=1.
- Single candidate plus back-to-back: first&last SSD 7 at x=235,y=315 → din=0, addr=75835, frame_done_out=1; next-cycle first accepted without loss.
- Protocol errors:
  - first, mid, then a new first without a last → seq_error_out=1, only the second pixel is written.
  - Stray non-first beat in IDLE → no write.
- Reset mid-pixel: assert sys_rst after 2 of 4 beats → no write, outputs 0, next full pixel computed correctly.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline constants and the disparity-select state type.
package stereo_pkg;
    localparam int SSD_WIDTH  = 22;
    localparam int DISP_WIDTH = 8;
    localparam int IMG_W      = 240;
    localparam int IMG_H      = 320;
    localparam int X_W        = $clog2(IMG_W);
    localparam int Y_W        = $clog2(IMG_H);
    localparam int ADDR_W     = $clog2(IMG_W * IMG_H);
    localparam logic [DISP_WIDTH-1:0] INVALID_DISP = 8'hFF;

    typedef enum logic {DS_IDLE, DS_ACCUM} ds_state_t;
endpackage

// File: rtl/disparity_select_min_tracker.sv
// Running minimum of SSD scores across the candidates of one left pixel.
// o_nxt_* include the current beat, so the top can register a result on the last beat.
module min_tracker
    import stereo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_beat,
    input  logic [SSD_WIDTH-1:0]  i_ssd,
    output logic [SSD_WIDTH-1:0]  o_nxt_ssd,
    output logic [DISP_WIDTH-1:0] o_nxt_disp
);
    localparam logic [DISP_WIDTH-1:0] CNT_MAX = '1;

    logic [SSD_WIDTH-1:0]  r_best_ssd;
    logic [DISP_WIDTH-1:0] r_best_disp;
    logic [DISP_WIDTH-1:0] r_cnt;
    logic [SSD_WIDTH-1:0]  w_ssd;
    logic [DISP_WIDTH-1:0] w_disp;
    logic [DISP_WIDTH-1:0] w_cnt;

    // A saturated counter no longer names a real offset, so it never wins.
    always_comb begin
        w_ssd  = r_best_ssd;
        w_disp = r_best_disp;
        w_cnt  = r_cnt;
        if (i_start) begin
            w_ssd  = i_ssd;
            w_disp = '0;
            w_cnt  = DISP_WIDTH'(1);
        end else if (i_beat && r_cnt != CNT_MAX) begin
            if (i_ssd < r_best_ssd) begin
                w_ssd  = i_ssd;
                w_disp = r_cnt;
            end
            w_cnt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_ssd  <= '1;
            r_best_disp <= '0;
            r_cnt       <= '0;
        end else begin
            r_best_ssd  <= w_ssd;
            r_best_disp <= w_disp;
            r_cnt       <= w_cnt;
        end
    end

    assign o_nxt_ssd  = w_ssd;
    assign o_nxt_disp = w_disp;
endmodule

// File: rtl/disparity_select.sv
// Winner-take-all disparity selection: picks the min-SSD offset per pixel and
// writes it to the result BRAM one cycle after the last candidate.
module disparity_select
    import stereo_pkg::*;
#(
    parameter int                   X_LAST     = 235,
    parameter int                   Y_LAST     = 315,
    parameter logic [SSD_WIDTH-1:0] SSD_THRESH = '1
) (
    input  logic                  clk_100mhz,
    input  logic                  sys_rst,
    input  logic                  ssd_valid_in,
    input  logic [SSD_WIDTH-1:0]  ssd_in,
    input  logic                  ssd_first_in,
    input  logic                  ssd_last_in,
    input  logic [X_W-1:0]        left_x_in,
    input  logic [Y_W-1:0]        left_y_in,
    output logic                  result_we,
    output logic [ADDR_W-1:0]     result_addr,
    output logic [DISP_WIDTH-1:0] result_din,
    output logic                  disp_valid_out,
    output logic [DISP_WIDTH-1:0] disp_out,
    output logic                  frame_done_out,
    output logic                  seq_error_out
);
    ds_state_t             r_state, w_nxt_state;
    logic                  w_start, w_beat, w_emit, w_err;
    logic [X_W-1:0]        r_x, w_x;
    logic [Y_W-1:0]        r_y, w_y;
    logic [SSD_WIDTH-1:0]  w_best_ssd;
    logic [DISP_WIDTH-1:0] w_best_disp, w_disp;
    logic                  r_we, r_fd, r_err;
    logic [ADDR_W-1:0]     r_addr;
    logic [DISP_WIDTH-1:0] r_din;

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) r_state <= DS_IDLE;
        else         r_state <= w_nxt_state;
    end

    // A first beat always (re)starts a pixel; one seen mid-pixel is an error.
    always_comb begin
        w_nxt_state = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        if (ssd_valid_in) begin
            if (ssd_first_in) begin
                w_start     = 1'b1;
                w_err       = (r_state == DS_ACCUM);
                w_emit      = ssd_last_in;
                w_nxt_state = ssd_last_in ? DS_IDLE : DS_ACCUM;
            end else if (r_state == DS_ACCUM) begin
                w_beat = 1'b1;
                if (ssd_last_in) begin
                    w_emit      = 1'b1;
                    w_nxt_state = DS_IDLE;
                end
            end else begin
                w_err = 1'b1;
            end
        end
    end

    min_tracker u_min (
        .clk        (clk_100mhz),
        .rst        (sys_rst),
        .i_start    (w_start),
        .i_beat     (w_beat),
        .i_ssd      (ssd_in),
        .o_nxt_ssd  (w_best_ssd),
        .o_nxt_disp (w_best_disp)
    );

    assign w_x    = w_start ? left_x_in : r_x;
    assign w_y    = w_start ? left_y_in : r_y;
    assign w_disp = (w_best_ssd > SSD_THRESH) ? INVALID_DISP : w_best_disp;

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_we   <= 1'b0;
            r_fd   <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_x   <= w_x;
            r_y   <= w_y;
            r_we  <= w_emit;
            r_fd  <= w_emit && (w_x == X_W'(X_LAST)) && (w_y == Y_W'(Y_LAST));
            r_err <= r_err | w_err;
            if (w_emit) begin
                r_addr <= ADDR_W'(IMG_W) * ADDR_W'(w_y) + ADDR_W'(w_x);
                r_din  <= w_disp;
            end
        end
    end

    assign result_we      = r_we;
    assign disp_valid_out = r_we;
    assign result_addr    = r_addr;
    assign result_din     = r_din;
    assign disp_out       = r_din;
    assign frame_done_out = r_fd;
    assign seq_error_out  = r_err;
endmodule

// File: tb/tb_disparity_select.sv
// Table-driven bench for disparity_select with a queue scoreboard of expected writes.
module tb_disparity_select;
    logic        clk_100mhz = 1'b0;
    logic        sys_rst;
    logic        ssd_valid_in, ssd_first_in, ssd_last_in;
    logic [21:0] ssd_in;
    logic [7:0]  left_x_in;
    logic [8:0]  left_y_in;
    logic        result_we, disp_valid_out, frame_done_out, seq_error_out;
    logic [16:0] result_addr;
    logic [7:0]  result_din, disp_out;

    disparity_select #(.X_LAST(235), .Y_LAST(315), .SSD_THRESH(22'd1000)) dut (
        .clk_100mhz    (clk_100mhz),
        .sys_rst       (sys_rst),
        .ssd_valid_in  (ssd_valid_in),
        .ssd_in        (ssd_in),
        .ssd_first_in  (ssd_first_in),
        .ssd_last_in   (ssd_last_in),
        .left_x_in     (left_x_in),
        .left_y_in     (left_y_in),
        .result_we     (result_we),
        .result_addr   (result_addr),
        .result_din    (result_din),
        .disp_valid_out(disp_valid_out),
        .disp_out      (disp_out),
        .frame_done_out(frame_done_out),
        .seq_error_out (seq_error_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        logic [7:0]       x;
        logic [8:0]       y;
        int               n;
        logic [3:0][21:0] s;
        int               gap;
        logic [16:0]      addr;
        logic [7:0]       din;
        logic             fd;
    } vec_t;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  din;
        logic        fd;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0, nerr = 0, cyc = 0, nwrites = 0;
    vec_t vt[9];

    always @(posedge clk_100mhz) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_100mhz) begin
        if (result_we || disp_valid_out) begin
            exp_t e;
            nwrites++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", result_addr, 32'h1FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("we", result_we, 1);
                chk("disp_valid", disp_valid_out, 1);
                chk("latency_cycle", cyc, e.due);
                chk("addr", result_addr, e.addr);
                chk("din", result_din, e.din);
                chk("disp_out", disp_out, e.din);
                chk("frame_done", frame_done_out, e.fd);
            end
        end else if (frame_done_out) begin
            chk("frame_done_without_write", frame_done_out, 0);
        end
    end

    function automatic vec_t mk(input int x, y, n, s0, s1, s2, s3, gap, addr, din, fd);
        vec_t v;
        v.x = x[7:0]; v.y = y[8:0]; v.n = n;
        v.s[0] = s0[21:0]; v.s[1] = s1[21:0]; v.s[2] = s2[21:0]; v.s[3] = s3[21:0];
        v.gap = gap; v.addr = addr[16:0]; v.din = din[7:0]; v.fd = fd[0];
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_100mhz);
            ssd_valid_in = 0; ssd_first_in = 0; ssd_last_in = 0;
        end
    endtask

    task automatic beat(input logic f, l, input logic [7:0] x, input logic [8:0] y, input logic [21:0] s);
        @(negedge clk_100mhz);
        ssd_valid_in = 1; ssd_first_in = f; ssd_last_in = l;
        left_x_in = x; left_y_in = y; ssd_in = s;
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            beat(i == 0, i == v.n - 1, v.x, v.y, v.s[i]);
            if (i == v.n - 1) begin
                e.addr = v.addr; e.din = v.din; e.fd = v.fd; e.due = cyc + 1;
                exp_q.push_back(e);
            end else if (v.gap > 0) begin
                idle(v.gap);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, result_we, 0);
        chk({tag, "_valid"}, disp_valid_out, 0);
        chk({tag, "_addr"}, result_addr, 0);
        chk({tag, "_din"}, result_din, 0);
        chk({tag, "_disp"}, disp_out, 0);
        chk({tag, "_fd"}, frame_done_out, 0);
        chk({tag, "_err"}, seq_error_out, 0);
    endtask

    initial begin
        int w0;
        sys_rst = 1; ssd_valid_in = 0; ssd_first_in = 0; ssd_last_in = 0;
        ssd_in = '0; left_x_in = '0; left_y_in = '0;
        //        x    y   n   s0    s1    s2   s3  gap  addr   din   fd
        vt[0] = mk(10,  20, 4, 500,  300,  100, 400, 0, 4810,  2,    0);
        vt[1] = mk(1,   1,  3, 50,   50,   70,  0,   0, 241,   0,    0);
        vt[2] = mk(2,   2,  2, 2000, 1500, 0,   0,   0, 482,   255,  0);
        vt[3] = mk(3,   2,  2, 2000, 900,  0,   0,   2, 483,   1,    0);
        vt[4] = mk(235, 315,1, 7,    0,    0,   0,   0, 75835, 0,    1);
        vt[5] = mk(0,   0,  3, 9,    3,    5,   0,   0, 0,     1,    0);
        vt[6] = mk(100, 100,4, 9,    8,    7,   1,   1, 24100, 3,    0);
        vt[7] = mk(235, 0,  2, 4,    4,    0,   0,   0, 235,   0,    0);
        vt[8] = mk(0,   315,1, 1001, 0,    0,   0,   0, 75600, 255,  0);
        idle(3);
        chk_zero("reset");
        sys_rst = 0;

        // Table vectors are sent back-to-back: each first follows the previous last.
        for (int i = 0; i < 9; i++) send(vt[i]);
        idle(4);
        chk("table_all_written", exp_q.size(), 0);
        chk("no_err_clean", seq_error_out, 0);

        // First without a preceding last: only the restarted pixel is written.
        beat(1, 0, 8'd5, 9'd5, 22'd100);
        beat(0, 0, 8'd5, 9'd5, 22'd50);
        send(mk(6, 5, 3, 30, 80, 10, 0, 0, 1206, 2, 0));
        idle(3);
        chk("seq_err_restart", seq_error_out, 1);
        chk("restart_written", exp_q.size(), 0);

        // Stray non-first beat while idle must not write.
        w0 = nwrites;
        beat(0, 1, 8'd7, 9'd7, 22'd1);
        idle(4);
        chk("stray_no_write", nwrites, w0);
        chk("stray_err_held", seq_error_out, 1);

        // Reset in the middle of a pixel discards it.
        w0 = nwrites;
        beat(1, 0, 8'd3, 9'd4, 22'd5);
        beat(0, 0, 8'd3, 9'd4, 22'd2);
        @(negedge clk_100mhz);
        ssd_valid_in = 0; ssd_first_in = 0; ssd_last_in = 0; sys_rst = 1;
        @(negedge clk_100mhz);
        chk_zero("midrst");
        sys_rst = 0;
        idle(2);
        chk("midrst_no_write", nwrites, w0);
        send(mk(3, 4, 4, 40, 20, 30, 10, 0, 963, 3, 0));
        idle(4);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
